ctrl_alu_sched: RTL
===================

Name: ctrl_alu_sched

Overview:
- Shares one control (branch/jump) ALU between two issue lanes using round-robin arbitration.
- Registers the granted packet into an ALU issue stage and registers the ALU result into a resolve stage.
- When the ALU reports a mispredict, runs a fixed-length recovery sequence that redirects fetch and blocks new grants.
- Sits between the issue queue select logic and the control ALU in the execute stage.

Parameters:
- PKT_W, 128: width of the opaque operand packet (data1, data2, immediate, opcode, predicted target/direction, pc) passed to the ALU.
- TAG_W, 5: width of the branch tag (checkpoint ID).
- RECOVER_CYCLES, 3: number of cycles recover_o stays high per mispredict; legal range 1..15.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid_i  in  1  lane 0 has a control instruction.
- req0_pkt_i  in  PKT_W  lane 0 operand packet.
- req0_tag_i  in  TAG_W  lane 0 branch tag.
- req0_ready_o  out  1  lane 0 accepted this cycle when valid&&ready.
- req1_valid_i, req1_pkt_i, req1_tag_i, req1_ready_o: same as lane 0, for lane 1.
- alu_valid_o  out  1  issue-stage register valid.
- alu_pkt_o  out  PKT_W  issue-stage packet driven to the ALU.
- alu_nextPC_i  in  32  combinational ALU next PC.
- alu_flags_i  in  8  combinational ALU flags; bit0 = mispredict.
- resolve_valid_o  out  1  registered resolve valid.
- resolve_tag_o  out  TAG_W  resolved branch tag.
- resolve_mispredict_o  out  1  resolved branch mispredicted.
- recover_o  out  1  recovery in progress; flush younger instructions.
- recover_pc_o  out  32  redirect PC, held while recover_o is high.
- recover_tag_o  out  TAG_W  tag of the mispredicted branch.
- stat_resolved_o  out  32  see Optional Feature.
- stat_mispred_o  out  32  see Optional Feature.

Behaviour:
- States: RUN and RECOVER. Reset sets state=RUN and rr_ptr=0, and clears every output register to 0 (all valids, tags, PCs and counters).
- Mispredict detect: mp_now = alu_valid_o && alu_flags_i[0].
- Ready (combinational): reqN_ready_o = (state==RUN) && !mp_now && grantN.
- Arbitration:
  - Only lane 0 valid: grant 0.
  - Only lane 1 valid: grant 1.
  - Both valid: grant lane rr_ptr.
  - After any grant, rr_ptr = the other lane. With no grant, rr_ptr is held.
- Issue stage: updates every cycle (the ALU never stalls).
  - alu_valid_o <= handshake occurred.
  - alu_pkt_o and the internal tag load the granted lane's packet and tag.
  - When there is no handshake, alu_pkt_o holds its value.
- Latency:
  - Packet accepted in cycle t appears on alu_pkt_o in t+1.
  - resolve_valid_o/tag/mispredict appear in t+2.
- Resolve stage: resolve_valid_o <= alu_valid_o; resolve_mispredict_o <= mp_now; resolve_tag_o <= issue tag.
- RUN -> RECOVER when mp_now.
  - Next cycle: recover_o=1, recover_pc_o=alu_nextPC_i (captured), recover_tag_o=issue tag, cnt=RECOVER_CYCLES-1.
- RECOVER behaviour:
  - Decrement cnt each cycle. When cnt==0, go to RUN and drop recover_o.
  - recover_o is high for exactly RECOVER_CYCLES cycles.
  - recover_pc_o and recover_tag_o hold their values afterwards.
- Grants are blocked in the mispredict cycle and throughout RECOVER. No instruction younger than the mispredicting branch enters the ALU.
- The first grant after recovery can occur in the cycle after recover_o falls.
- Requests are not queued. Lanes hold valid until accepted. A lane's request may be withdrawn during recovery (squash).
- Reset during RECOVER: recover_o=0 and state=RUN from the next cycle. The in-flight issue/resolve entries are dropped.

Optional Feature:
- Macro: CTRL_SCHED_STATS_EN.
- When defined:
  - stat_resolved_o increments on each resolve_valid_o.
  - stat_mispred_o increments on each resolve_valid_o && resolve_mispredict_o.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined: the ports exist but are tied to 0, and no counter logic is present.

Test Plan:
- Both lanes valid for 4 cycles, no mispredict: grants alternate 0,1,0,1; resolve tags appear 2 cycles after each acceptance.
- Single lane 1 valid, tag 7, flags 0x00 -> alu_valid_o in t+1; resolve_valid_o=1, tag 7, mispredict 0 in t+2.
- Lane 0 tag 3 with flags 0xA5 (bit0=1) and nextPC 0x0040_0120:
  - Both readies are 0 in the detect cycle.
  - recover_o is high for 3 cycles with recover_pc_o 0x0040_0120 and recover_tag_o 3.
  - The first new grant comes 1 cycle after recover_o falls.
- Reset asserted in the 2nd recovery cycle -> recover_o=0, all outputs 0 next cycle; a request then granted to lane 0 (rr_ptr=0).
- With CTRL_SCHED_STATS_EN, 10 resolves of which 4 mispredict -> stat_resolved_o=10, stat_mispred_o=4; with counters preloaded to 0xFFFFFFFF they stay saturated.

Source files
------------

// File: rtl/ctrl_alu_sched.sv
// ctrl_alu_sched: shares one control (branch/jump) ALU between two issue lanes
// with round-robin arbitration, an issue register feeding the ALU, a resolve
// register behind it, and a fixed-length recovery sequence on mispredict.
// Optional build macro CTRL_SCHED_STATS_EN adds saturating resolve/mispredict
// counters; without it the stat ports read as zero.
//
// state   | meaning
// RUN     | normal arbitration; one grant per cycle into the ALU
// RECOVER | fetch redirect in progress; grants blocked; cnt = cycles left - 1
module ctrl_alu_sched #(
  parameter int PKT_W          = 128,
  parameter int TAG_W          = 5,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid_i,
  input  logic [PKT_W-1:0] req0_pkt_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [PKT_W-1:0] req1_pkt_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             req1_ready_o,
  output logic             alu_valid_o,
  output logic [PKT_W-1:0] alu_pkt_o,
  input  logic [31:0]      alu_nextPC_i,
  input  logic [7:0]       alu_flags_i,
  output logic             resolve_valid_o,
  output logic [TAG_W-1:0] resolve_tag_o,
  output logic             resolve_mispredict_o,
  output logic             recover_o,
  output logic [31:0]      recover_pc_o,
  output logic [TAG_W-1:0] recover_tag_o,
  output logic [31:0]      stat_resolved_o,
  output logic [31:0]      stat_mispred_o
);

  typedef enum logic {RUN, RECOVER} state_t;

  localparam logic [3:0] CNT_INIT = 4'(RECOVER_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             rr_ptr;
  logic [TAG_W-1:0] issue_tag;
  logic             mp_now, grant0, grant1, hs0, hs1, hs;
  logic             unused_flags;

  // Only flag bit 0 (mispredict) matters to the scheduler
  assign unused_flags = ^alu_flags_i[7:1];
  assign recover_o    = (state == RECOVER);

  // Round-robin grant, gated off during the mispredict cycle and recovery
  always_comb begin
    mp_now       = alu_valid_o && alu_flags_i[0];
    grant0       = req0_valid_i && (!req1_valid_i || !rr_ptr);
    grant1       = req1_valid_i && (!req0_valid_i || rr_ptr);
    req0_ready_o = (state == RUN) && !mp_now && grant0;
    req1_ready_o = (state == RUN) && !mp_now && grant1;
    hs0          = req0_valid_i && req0_ready_o;
    hs1          = req1_valid_i && req1_ready_o;
    hs           = hs0 || hs1;
  end

  // State and recovery counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: enter RECOVER on a mispredict, leave once the count expires
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (mp_now) begin
          state_nxt = RECOVER;
          cnt_nxt   = CNT_INIT;
        end
      end
      RECOVER: begin
        if (cnt == 4'd0) state_nxt = RUN;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Issue, resolve and redirect capture registers plus round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr               <= 1'b0;
      alu_valid_o          <= 1'b0;
      alu_pkt_o            <= '0;
      issue_tag            <= '0;
      resolve_valid_o      <= 1'b0;
      resolve_tag_o        <= '0;
      resolve_mispredict_o <= 1'b0;
      recover_pc_o         <= '0;
      recover_tag_o        <= '0;
    end else begin
      alu_valid_o <= hs;
      if (hs) begin
        alu_pkt_o <= hs0 ? req0_pkt_i : req1_pkt_i;
        issue_tag <= hs0 ? req0_tag_i : req1_tag_i;
        rr_ptr    <= hs0;
      end
      resolve_valid_o      <= alu_valid_o;
      resolve_mispredict_o <= mp_now;
      resolve_tag_o        <= issue_tag;
      if ((state == RUN) && mp_now) begin
        recover_pc_o  <= alu_nextPC_i;
        recover_tag_o <= issue_tag;
      end
    end
  end

`ifdef CTRL_SCHED_STATS_EN
  // Saturating counters of resolved branches and mispredicts
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_resolved_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (resolve_valid_o && (stat_resolved_o != 32'hFFFF_FFFF))
        stat_resolved_o <= stat_resolved_o + 32'd1;
      if (resolve_valid_o && resolve_mispredict_o && (stat_mispred_o != 32'hFFFF_FFFF))
        stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`else
  assign stat_resolved_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule
